// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared states, response codes and AXI encodings for axi_sram_slave.
package axi_sram_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RADDR, S_RDATA} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

// File: rtl/sram_sp_bytewe.sv
// sram_sp_bytewe: single-port 32-bit RAM with byte write enables and a registered read port that holds when idle.
module sram_sp_bytewe #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR-burst responder over a single-port SRAM, one transaction at a time.
// AXI_SRAM_DECERR_EN enables the address range check (DECERR); otherwise word indices alias modulo DEPTH_WORDS.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic        s_axi_wlast,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t r_state, w_next;
  logic r_last_rd, r_wl_err, r_rlast;
  logic [AW-1:0] r_addr, w_idx;
  logic [7:0] r_cnt, w_len;
  logic [1:0] r_err, w_err, w_burst;
  logic [2:0] w_size;
  logic [31:0] w_addr, w_q;
  logic [3:0] w_we;
  logic w_gw, w_gr, w_w_hs, w_r_hs, w_issue, w_oob;
  // Ties go to whichever channel lost the previous grant.
  assign w_gw = r_state == S_IDLE && s_axi_awvalid && (!s_axi_arvalid || r_last_rd);
  assign w_gr = r_state == S_IDLE && s_axi_arvalid && (!s_axi_awvalid || !r_last_rd);
  assign w_addr = w_gr ? s_axi_araddr : s_axi_awaddr;
  assign w_len = w_gr ? s_axi_arlen : s_axi_awlen;
  assign w_size = w_gr ? s_axi_arsize : s_axi_awsize;
  assign w_burst = w_gr ? s_axi_arburst : s_axi_awburst;
`ifdef AXI_SRAM_DECERR_EN
  logic [31:0] w_word, w_end;
  assign w_word = (w_addr - ADDR_BASE) >> 2;
  assign w_end = w_word + 32'(w_len);
  assign w_oob = w_word >= 32'(DEPTH_WORDS) || w_end >= 32'(DEPTH_WORDS);
  assign w_idx = w_word[AW-1:0];
`else
  assign w_oob = 1'b0;
  assign w_idx = AW'((w_addr - ADDR_BASE) >> 2);
`endif
  assign w_err = (w_size != AXI_SIZE_4B || w_burst != AXI_BURST_INCR) ? RESP_SLVERR :
                 w_oob ? RESP_DECERR : RESP_OKAY;
  assign w_w_hs = r_state == S_WDATA && s_axi_wvalid;
  assign w_r_hs = r_state == S_RDATA && s_axi_rready;
  // The output register is always full in RDATA, so the next read is issued exactly on a handshake.
  assign w_issue = r_state == S_RADDR || (w_r_hs && r_cnt != 8'd0);
  assign w_we = (w_w_hs && r_err == RESP_OKAY) ? s_axi_wstrb : 4'b0000;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_gr ? S_RADDR : w_gw ? S_WDATA : S_IDLE;
      S_WDATA: w_next = (w_w_hs && r_cnt == 8'd0) ? S_WRESP : S_WDATA;
      S_WRESP: w_next = s_axi_bready ? S_IDLE : S_WRESP;
      S_RADDR: w_next = S_RDATA;
      S_RDATA: w_next = (w_r_hs && r_cnt == 8'd0) ? S_IDLE : S_RDATA;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last_rd <= 1'b0;
      r_addr <= '0;
      r_cnt <= 8'd0;
      r_err <= RESP_OKAY;
      r_wl_err <= 1'b0;
      r_rlast <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gw || w_gr) begin
        r_last_rd <= w_gr;
        r_addr <= w_idx;
        r_cnt <= w_len;
        r_err <= w_err;
        r_wl_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_addr <= r_addr + 1'b1;
        r_cnt <= r_cnt - 8'd1;
        if (s_axi_wlast != (r_cnt == 8'd0)) r_wl_err <= 1'b1;
      end
      if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_rlast <= (r_state == S_RADDR) ? r_cnt == 8'd0 : r_cnt == 8'd1;
        if (r_state == S_RDATA) r_cnt <= r_cnt - 8'd1;
      end else if (w_r_hs) begin
        r_rlast <= 1'b0;
      end
    end
  end
  sram_sp_bytewe #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk),
    .i_re(w_issue),
    .i_we(w_we),
    .i_addr(r_addr),
    .i_wdata(s_axi_wdata),
    .o_rdata(w_q)
  );
  assign s_axi_awready = w_gw;
  assign s_axi_arready = w_gr;
  assign s_axi_wready = r_state == S_WDATA;
  assign s_axi_bvalid = r_state == S_WRESP;
  assign s_axi_bresp = !s_axi_bvalid ? RESP_OKAY : (r_err == RESP_OKAY && r_wl_err) ? RESP_SLVERR : r_err;
  assign s_axi_rvalid = r_state == S_RDATA;
  assign s_axi_rdata = (s_axi_rvalid && r_err == RESP_OKAY) ? w_q : 32'h0;
  assign s_axi_rresp = s_axi_rvalid ? r_err : RESP_OKAY;
  assign s_axi_rlast = r_rlast;
endmodule
